// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep sequencer: FSM encoding, truth-table
// constants and the vector-index to gate-input mapping.
package gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Vector index n drives {b,a} = n, so a is bit 0 and b is bit 1.
    function automatic logic [1:0] idx_to_ba(input logic [1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable 4-bit down-counter that holds at zero; zero flags the end of a
// settle interval.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign zero = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Steps a 2-input gate through all four input vectors, samples its output
// after a settle interval and reports per-vector mismatches against EXPECT.
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  EXPECT = TT_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       loop_en,
    input  logic       c_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    localparam logic [3:0] WLOAD = 4'(SETTLE - 1);

    state_t     r_state,     w_state_nxt;
    logic [1:0] r_idx,       w_idx_nxt;
    logic [3:0] r_work_mask, w_work_mask_nxt;
    logic [2:0] r_work_cnt,  w_work_cnt_nxt;
    logic       r_busy,      w_busy_nxt;
    logic       r_done,      w_done_nxt;
    logic       r_pass,      w_pass_nxt;
    logic [3:0] r_fail_mask, w_fail_mask_nxt;
    logic [2:0] r_err_count, w_err_count_nxt;

    logic       w_tmr_load;
    logic       w_tmr_en;
    logic       w_tmr_zero;
    logic       w_mis;
    logic [3:0] w_mask_fin;
    logic [2:0] w_cnt_fin;
    logic [1:0] w_ba;

    settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .en       (w_tmr_en),
        .load_val (WLOAD),
        .zero     (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_work_mask <= 4'd0;
            r_work_cnt  <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 4'd0;
            r_err_count <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_work_mask <= w_work_mask_nxt;
            r_work_cnt  <= w_work_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_work_mask_nxt = r_work_mask;
        w_work_cnt_nxt  = r_work_cnt;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_fail_mask_nxt = r_fail_mask;
        w_err_count_nxt = r_err_count;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;

        // Mismatch for the vector currently on the gate, folded into the
        // working results so the last vector can be committed on its own edge.
        w_mis             = c_i ^ EXPECT[r_idx];
        w_mask_fin        = r_work_mask;
        w_mask_fin[r_idx] = w_mis;
        w_cnt_fin         = r_work_cnt + 3'(w_mis);

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_idx_nxt       = 2'd0;
                    w_work_mask_nxt = 4'd0;
                    w_work_cnt_nxt  = 3'd0;
                    w_busy_nxt      = 1'b1;
                    w_tmr_load      = 1'b1;
                    w_state_nxt     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_tmr_en = 1'b1;
                if (w_tmr_zero) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_work_mask_nxt = w_mask_fin;
                w_work_cnt_nxt  = w_cnt_fin;
                if (r_idx != 2'd3) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_fail_mask_nxt = w_mask_fin;
                    w_err_count_nxt = w_cnt_fin;
                    w_pass_nxt      = (w_cnt_fin == 3'd0);
                    w_done_nxt      = 1'b1;
                    w_idx_nxt       = 2'd0;
                    w_work_mask_nxt = 4'd0;
                    w_work_cnt_nxt  = 3'd0;
                    if (loop_en) begin
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_ba      = idx_to_ba(r_idx);
    assign a_o       = w_ba[0];
    assign b_o       = w_ba[1];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1/NOR and SETTLE=3/XOR),
// each driving a modelled gate; done pulses are checked from a result queue.
module tb_gate_sweep_ctrl;

    typedef struct {
        int         cyc;
        logic       pass;
        logic [3:0] mask;
        logic [2:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic       start_a, loop_a, c_a, a_a, b_a, busy_a, done_a, pass_a;
    logic [3:0] mask_a;
    logic [2:0] cnt_a;
    logic       start_b, loop_b, c_b, a_b, b_b, busy_b, done_b, pass_b;
    logic [3:0] mask_b;
    logic [2:0] cnt_b;
    int         gsel;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: 0 = NOR, 1 = output stuck at 0, 2 = output stuck at 1.
    assign c_a = (gsel == 0) ? ~(a_a | b_a) : (gsel == 2);
    assign c_b = ~(a_b | b_b);

    gate_sweep_ctrl #(.SETTLE(1), .EXPECT(4'b0001)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .loop_en(loop_a), .c_i(c_a),
        .a_o(a_a), .b_o(b_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(mask_a), .err_count(cnt_a)
    );

    gate_sweep_ctrl #(.SETTLE(3), .EXPECT(4'b0110)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .loop_en(loop_b), .c_i(c_b),
        .a_o(a_b), .b_o(b_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(mask_b), .err_count(cnt_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_done(input string nm, input exp_t e, input logic p,
                            input logic [3:0] m, input logic [2:0] c);
        check({nm, "_cyc"}, cyc, e.cyc);
        check({nm, "_res"}, {24'd0, p, m, c}, {24'd0, e.pass, e.mask, e.cnt});
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) check("a_unexpected_done", 1, 0);
            else cmp_done("a_done", q_a.pop_front(), pass_a, mask_a, cnt_a);
        end
    end

    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) check("b_unexpected_done", 1, 0);
            else cmp_done("b_done", q_b.pop_front(), pass_b, mask_b, cnt_b);
        end
    end

    task automatic wait_idle_a(input int lim);
        int n = 0;
        while (busy_a && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("a_idle_timeout", busy_a, 0);
    endtask

    task automatic wait_idle_b(input int lim);
        int n = 0;
        while (busy_b && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("b_idle_timeout", busy_b, 0);
    endtask

    task automatic sweep_a(input logic p, input logic [3:0] m, input logic [2:0] c);
        start_a = 1'b1;
        q_a.push_back('{cyc + 1 + 8, p, m, c});
        @(negedge clk);
        start_a = 1'b0;
        wait_idle_a(40);
        @(negedge clk);
    endtask

    initial begin
        int   k;
        logic busy_ok;
        rst = 1'b1; start_a = 1'b0; loop_a = 1'b0; start_b = 1'b0; loop_b = 1'b0;
        gsel = 0;
        repeat (3) @(negedge clk);
        check("reset_state", {21'd0, a_a, b_a, busy_a, done_a, pass_a, mask_a, cnt_a}, 0);
        rst = 1'b0;
        @(negedge clk);

        // NOR gate, single sweep, vector order and hold time.
        start_a = 1'b1;
        k = cyc + 1;
        q_a.push_back('{k + 8, 1'b1, 4'b0000, 3'd0});
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("vec_first", {30'd0, b_a, a_a}, n);
            @(negedge clk);
            check("vec_hold", {29'd0, busy_a, b_a, a_a}, 4 + n);
            @(negedge clk);
        end
        check("busy_after_commit", busy_a, 0);
        repeat (2) @(negedge clk);

        // Stuck-at outputs against the NOR table.
        gsel = 1;
        sweep_a(1'b0, 4'b0001, 3'd1);
        gsel = 2;
        sweep_a(1'b0, 4'b1110, 3'd3);
        gsel = 0;

        // Loop mode: four back-to-back sweeps, stray start ignored.
        loop_a  = 1'b1;
        start_a = 1'b1;
        k = cyc + 1;
        for (int s = 1; s <= 4; s++) q_a.push_back('{k + 8 * s, 1'b1, 4'b0000, 3'd0});
        @(negedge clk);
        start_a = 1'b0;
        busy_ok = 1'b1;
        while (cyc < k + 32) begin
            if (busy_a !== 1'b1) busy_ok = 1'b0;
            if (cyc == k + 12) start_a = 1'b1;
            if (cyc == k + 13) start_a = 1'b0;
            if (cyc == k + 26) loop_a = 1'b0;
            @(negedge clk);
        end
        check("loop_busy_held", busy_ok, 1);
        check("loop_busy_fall", busy_a, 0);
        repeat (4) @(negedge clk);

        // Reset during the second sample cycle aborts without a done pulse.
        start_a = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_sweep", {21'd0, a_a, b_a, busy_a, done_a, pass_a, mask_a, cnt_a}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        sweep_a(1'b1, 4'b0000, 3'd0);

        // SETTLE=3, XOR table on a NOR gate, start held high.
        start_b = 1'b1;
        k = cyc + 1;
        for (int s = 0; s < 3; s++) q_b.push_back('{k + 16 + 17 * s, 1'b0, 4'b0111, 3'd3});
        @(negedge clk);
        repeat (16) @(negedge clk);
        check("held_busy_gap", busy_b, 0);
        @(negedge clk);
        check("held_busy_reaccept", busy_b, 1);
        repeat (17) @(negedge clk);
        start_b = 1'b0;
        wait_idle_b(60);
        repeat (4) @(negedge clk);

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
